ingress_port_requester: RTL and testbench
=========================================

Name: ingress_port_requester

Overview:
- Per-input-port front end of the 4-port switch. Buffers incoming packet beats in a FIFO and presents the header's one-hot destination mask to the crossbar arbiter as a request.
- Streams the packet to the crossbar one beat per granted cycle and withdraws its request at end of packet.
- Four instances sit between the input MACs and the arbiter. Each instance's port_dst feeds one of the arbiter's portN_dst inputs; its grant_bus[N] returns as grant.

Parameters:
- DATA_WIDTH, 8: beat width in bits; must be >= ADDR_WIDTH.
- FIFO_DEPTH, 16: beat capacity of the ingress buffer; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  upstream beat valid.
- in_data  in  DATA_WIDTH  upstream beat; first beat of a packet is the header, dst mask in [ADDR_WIDTH-1:0].
- in_last  in  1  marks the final beat of a packet.
- in_ready  out  1  FIFO can accept a beat.
- port_dst  out  ADDR_WIDTH  one-hot/multicast request mask to the arbiter; 0 means no request.
- grant  in  1  arbiter all-or-nothing grant for this port.
- out_valid  out  1  beat presented to the crossbar this cycle.
- out_data  out  DATA_WIDTH  beat to the crossbar.
- out_last  out  1  final beat of the packet.
- busy  out  1  state is not IDLE.
- drop_pulse  out  1  one-cycle pulse when a zero-mask packet finishes being discarded.

Behaviour:
- Reset: FIFO is flushed and state goes to IDLE. port_dst, out_valid, out_last, busy and drop_pulse are 0; in_ready is 0 while rst is high. Any partial packet is lost, and upstream restarts at a header.
- FIFO entries are {last, data}.
  - Write when in_valid && in_ready. in_ready = !full.
  - Full = FIFO_DEPTH entries; no write is accepted when full.
  - Read pointer wraps modulo FIFO_DEPTH. Pop and push in the same cycle are allowed when not full.
  - Head is registered: a beat written in cycle N is visible at the head in cycle N+1.
- State machine: IDLE, REQ, XMIT, DROP.
  - IDLE: wait for FIFO non-empty. Because the FIFO is non-empty, the head is by construction a header. Go to REQ if head[ADDR_WIDTH-1:0] != 0, else go to DROP.
  - REQ: port_dst = head[ADDR_WIDTH-1:0], driven combinationally; the mask is captured into held_dst. On grant:
    - out_valid = 1, out_data = head data, out_last = head last; pop the FIFO.
    - If the header has last set, go to IDLE, else go to XMIT.
  - XMIT: port_dst = held_dst when the FIFO is non-empty, else 0. Deasserting on underrun avoids wasted grants. On grant with the FIFO non-empty: output the head beat and pop. If the beat has last set, clear held_dst and go to IDLE.
  - DROP: pop one beat per cycle while the FIFO is non-empty; port_dst = 0. On popping the last beat, pulse drop_pulse and go to IDLE.
- A grant arriving while port_dst == 0 is ignored: no pop and out_valid = 0.
- out_valid = grant && port_dst != 0, combinational, same cycle as the grant; latency from grant to beat is 0.
- Back-to-back packets: after a last beat leaves, the next header may be requested the following cycle (IDLE to REQ takes 1 cycle).
- Mid-packet grant loss (the arbiter rotating to another port): the port stays in XMIT with port_dst held and no beat emitted; it resumes on the next grant.

Optional Feature:
- Macro: PORT_STATS_EN.
- When defined, the block adds pkt_cnt (out, 16 bits) and stall_cnt (out, 16 bits), both saturating at 16'hFFFF and cleared by rst.
  - pkt_cnt increments on every emitted beat with out_last set.
  - stall_cnt increments on every cycle with port_dst != 0 && !grant.
- When undefined, both ports exist but are tied to 0 and no counter flops are synthesized.

Decomposition:
- packet_pkg (extend): ADDR_WIDTH; a req_state_t enum {IDLE, REQ, XMIT, DROP}; localparam HDR_DST_LSB = 0.
- Sub-module port_fifo: a synchronous FIFO with parameters DATA_WIDTH+1 and FIFO_DEPTH. Ports: push, pop, din, dout, empty, full. Its reset is the same async active-high rst.

Test Plan:
- Unicast: 3-beat packet, header 8'h02, grant held high → port_dst=4'b0010 one cycle after the header is written; beats out on 3 consecutive cycles, out_last on the 3rd, port_dst=0 afterwards.
- Multicast with grant gaps: header 8'h0A, 4-beat packet, grant pattern 1,0,0,1,1,1 → port_dst=4'b1010 throughout; beats emitted only on grant cycles; pkt_cnt=1 and stall_cnt=2 with PORT_STATS_EN.
- Zero-mask drop: header 8'h00, 2 beats → port_dst never asserts, out_valid stays 0, drop_pulse high for exactly one cycle, state returns to IDLE.
- Full/backpressure: 17 beats pushed with no grant, FIFO_DEPTH=16 → in_ready=0 after the 16th write and the 17th is held upstream; one granted pop → in_ready=1 the next cycle.
- Underrun: header plus beat 1 written, beat 2 delayed 5 cycles, grant tied high → port_dst=0 for the gap cycles, no out_valid; resumes with the correct beat when it arrives.
- Reset mid-XMIT: assert rst after the 2nd beat of 4 → all outputs 0 immediately; after release, a new header 8'h01 is requested normally.

Source files
------------

// File: rtl/packet_pkg.sv
// Shared switch definitions: destination mask width, header field position
// and the ingress requester state encoding.
package packet_pkg;

    localparam int ADDR_WIDTH  = 4;
    localparam int HDR_DST_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XMIT = 2'd2,
        DROP = 2'd3
    } req_state_t;

endpackage

// File: rtl/port_fifo.sv
// Synchronous FIFO with a registered head: a word written in cycle N is on
// dout in cycle N+1. Pushes while full and pops while empty are ignored.
module port_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign empty  = (r_count == '0);
    assign full   = (r_count == FULL_CNT);
    assign dout   = r_mem[r_rd_ptr];

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ingress_port_requester.sv
// Per-port switch front end: buffers beats, requests the header's destination
// mask from the arbiter and streams the packet on grant. PORT_STATS_EN adds counters.
module ingress_port_requester
    import packet_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] port_dst,
    input  logic                  grant,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  drop_pulse,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           stall_cnt,
    output req_state_t            dbg_state
);

    // Upstream beat transfers on a cycle with in_valid && in_ready; the
    // crossbar side moves a beat on every cycle with grant && port_dst != 0.

    req_state_t            r_state;
    req_state_t            w_next_state;
    logic [ADDR_WIDTH-1:0] r_held_dst;
    logic [ADDR_WIDTH-1:0] w_held_dst_nxt;
    logic [ADDR_WIDTH-1:0] w_port_dst;
    logic                  w_out_valid;
    logic                  w_pop;
    logic                  w_drop_pulse;
    logic                  w_push;
    logic                  w_empty;
    logic                  w_full;
    logic [DATA_WIDTH:0]   w_head;
    logic                  w_head_last;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [ADDR_WIDTH-1:0] w_head_dst;

    assign in_ready = !w_full && !rst;
    assign w_push   = in_valid && in_ready;

    port_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({in_last, in_data}),
        .dout  (w_head),
        .empty (w_empty),
        .full  (w_full)
    );

    assign w_head_last = w_head[DATA_WIDTH];
    assign w_head_data = w_head[DATA_WIDTH-1:0];
    assign w_head_dst  = w_head_data[HDR_DST_LSB +: ADDR_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_held_dst <= '0;
        end else begin
            r_state    <= w_next_state;
            r_held_dst <= w_held_dst_nxt;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_held_dst_nxt = r_held_dst;
        w_port_dst     = '0;
        w_pop          = 1'b0;
        w_drop_pulse   = 1'b0;
        w_out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                // A non-empty FIFO in IDLE always has a header at its head.
                if (!w_empty) begin
                    w_next_state = (w_head_dst != '0) ? REQ : DROP;
                end
            end
            REQ: begin
                w_port_dst     = w_head_dst;
                w_held_dst_nxt = w_head_dst;
                w_out_valid    = grant && (w_port_dst != '0);
                if (w_out_valid) begin
                    w_pop = 1'b1;
                    if (w_head_last) begin
                        w_held_dst_nxt = '0;
                        w_next_state   = IDLE;
                    end else begin
                        w_next_state = XMIT;
                    end
                end
            end
            XMIT: begin
                // Withdraw the request on underrun so grants are not wasted.
                if (!w_empty) begin
                    w_port_dst = r_held_dst;
                end
                w_out_valid = grant && (w_port_dst != '0);
                if (w_out_valid) begin
                    w_pop = 1'b1;
                    if (w_head_last) begin
                        w_held_dst_nxt = '0;
                        w_next_state   = IDLE;
                    end
                end
            end
            DROP: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_last) begin
                        w_drop_pulse = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign port_dst   = w_port_dst;
    assign out_valid  = w_out_valid;
    assign out_data   = w_out_valid ? w_head_data : '0;
    assign out_last   = w_out_valid && w_head_last;
    assign busy       = (r_state != IDLE);
    assign drop_pulse = w_drop_pulse;
    assign dbg_state  = r_state;

`ifdef PORT_STATS_EN
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_out_valid && w_head_last && (r_pkt_cnt != 16'hFFFF)) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            if ((w_port_dst != '0) && !grant && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign pkt_cnt   = r_pkt_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign pkt_cnt   = 16'd0;
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ingress_port_requester.sv
// Self-checking bench for ingress_port_requester: expected beats are queued as
// they are driven and compared when the crossbar side emits them.
module tb_ingress_port_requester;
    import packet_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic [DW-1:0]         in_data = '0;
    logic                  in_last = 1'b0;
    logic                  grant = 1'b0;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] port_dst;
    logic                  out_valid;
    logic [DW-1:0]         out_data;
    logic                  out_last;
    logic                  busy;
    logic                  drop_pulse;
    logic [15:0]           pkt_cnt;
    logic [15:0]           stall_cnt;
    req_state_t            dbg_state;

    ingress_port_requester #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .port_dst   (port_dst),
        .grant      (grant),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .drop_pulse (drop_pulse),
        .pkt_cnt    (pkt_cnt),
        .stall_cnt  (stall_cnt),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    logic [DW:0]           exp_q [$];
    int                    beat_cyc [$];
    logic [ADDR_WIDTH-1:0] exp_mask = '0;
    int n_checks    = 0;
    int n_pass      = 0;
    int beats_seen  = 0;
    int drops_seen  = 0;
    int dst_active  = 0;
    int cyc         = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard side: every emitted beat must match the oldest expected one.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (!rst) begin
            if (drop_pulse) drops_seen++;
            if (port_dst != '0) dst_active++;
            if (out_valid) begin
                beats_seen++;
                beat_cyc.push_back(cyc);
                e = 'x;
                if (exp_q.size() != 0) e = exp_q.pop_front();
                check_eq("beat", 32'({out_last, out_data}), 32'(e));
                check_eq("beat_dst", 32'(port_dst), 32'(exp_mask));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic l, input bit expect_out);
        int t;
        t = 0;
        if (expect_out) exp_q.push_back({l, d});
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) check_eq("push_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, sbase, pbase, dbase, abase, t;
        logic [5:0] pat;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_port_dst", 32'(port_dst), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_drop", 32'(drop_pulse), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        tick();
        check_eq("ready_after_rst", 32'(in_ready), 32'd1);

        // Unicast, grant held high
        grant = 1'b1;
        exp_mask = 4'b0010;
        beat_cyc.delete();
        push_beat(8'h02, 1'b0, 1'b1);
        push_beat(8'hA1, 1'b0, 1'b1);
        push_beat(8'hB2, 1'b1, 1'b1);
        wait_drain(50);
        check_eq("uni_consecutive", 32'(beat_cyc[2] - beat_cyc[0]), 32'd2);
        check_eq("uni_dst_after", 32'(port_dst), 32'd0);
        check_eq("uni_idle", 32'(busy), 32'd0);

        // Multicast with grant gaps 1,0,0,1,1,1
        grant = 1'b0;
        exp_mask = 4'b1010;
        push_beat(8'h0A, 1'b0, 1'b1);
        push_beat(8'h31, 1'b0, 1'b1);
        push_beat(8'h32, 1'b0, 1'b1);
        push_beat(8'h33, 1'b1, 1'b1);
        t = 0;
        while (port_dst == '0 && t < 10) begin
            tick();
            t++;
        end
        sbase = int'(stall_cnt);
        pbase = int'(pkt_cnt);
        pat = 6'b111001;
        for (int i = 0; i < 6; i++) begin
            grant = pat[i];
            @(negedge clk);
            check_eq("mc_dst", 32'(port_dst), 32'h0000_000A);
            tick();
        end
        grant = 1'b0;
        check_eq("mc_drained", 32'(exp_q.size()), 32'd0);
        check_eq("mc_idle_dst", 32'(port_dst), 32'd0);
`ifdef PORT_STATS_EN
        check_eq("mc_pkt_cnt", 32'(int'(pkt_cnt) - pbase), 32'd1);
        check_eq("mc_stall_cnt", 32'(int'(stall_cnt) - sbase), 32'd2);
`endif

        // Zero-mask packet is discarded without requesting
        grant = 1'b1;
        dbase = drops_seen;
        abase = dst_active;
        base  = beats_seen;
        push_beat(8'h00, 1'b0, 1'b0);
        push_beat(8'h55, 1'b1, 1'b0);
        t = 0;
        while (drops_seen == dbase && t < 20) begin
            tick();
            t++;
        end
        repeat (3) tick();
        check_eq("drop_pulses", 32'(drops_seen - dbase), 32'd1);
        check_eq("drop_no_req", 32'(dst_active - abase), 32'd0);
        check_eq("drop_no_beat", 32'(beats_seen - base), 32'd0);
        check_eq("drop_idle", 32'(dbg_state), 32'(IDLE));

        // Full FIFO backpressure
        grant = 1'b0;
        exp_mask = 4'b0100;
        push_beat(8'h04, 1'b0, 1'b1);
        for (int i = 1; i < 16; i++) push_beat(8'(8'h40 + i), 1'b0, 1'b1);
        exp_q.push_back({1'b1, 8'h50});
        in_valid = 1'b1;
        in_data  = 8'h50;
        in_last  = 1'b1;
        @(negedge clk);
        check_eq("full_ready", 32'(in_ready), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        check_eq("full_held", 32'(in_ready), 32'd0);
        check_eq("full_req", 32'(port_dst), 32'h0000_0004);
        @(posedge clk);
        #1;
        grant = 1'b1;
        @(negedge clk);
        check_eq("full_pop_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        grant = 1'b0;
        @(negedge clk);
        check_eq("ready_after_pop", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        grant = 1'b1;
        wait_drain(100);

        // Underrun: request withdrawn while the FIFO is empty mid-packet
        exp_mask = 4'b1000;
        push_beat(8'h08, 1'b0, 1'b1);
        push_beat(8'h61, 1'b0, 1'b1);
        wait_drain(20);
        base = beats_seen;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("ur_dst_gap", 32'(port_dst), 32'd0);
            tick();
        end
        check_eq("ur_busy", 32'(busy), 32'd1);
        check_eq("ur_no_beat", 32'(beats_seen - base), 32'd0);
        push_beat(8'h62, 1'b1, 1'b1);
        wait_drain(20);
        check_eq("ur_idle", 32'(dbg_state), 32'(IDLE));

        // Reset in the middle of a packet
        grant = 1'b0;
        exp_mask = 4'b0010;
        push_beat(8'h02, 1'b0, 1'b1);
        push_beat(8'h71, 1'b0, 1'b1);
        push_beat(8'h72, 1'b0, 1'b1);
        push_beat(8'h73, 1'b1, 1'b1);
        base = beats_seen;
        grant = 1'b1;
        t = 0;
        while (beats_seen - base < 2 && t < 20) begin
            @(posedge clk);
            t++;
        end
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_beats", 32'(beats_seen - base), 32'd2);
        check_eq("mid_rst_dst", 32'(port_dst), 32'd0);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_last", 32'(out_last), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_ready", 32'(in_ready), 32'd0);
`ifdef PORT_STATS_EN
        check_eq("mid_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check_eq("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        exp_mask = 4'b0001;
        push_beat(8'h01, 1'b1, 1'b1);
        wait_drain(20);
        check_eq("post_rst_idle", 32'(dbg_state), 32'(IDLE));
        grant = 1'b0;

        check_eq("final_queue", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
